fifo_controller: RTL and testbench

Synchronous FIFO controller that drives the write and read ports of the dual-port memory, turning it into a first-in/first-out buffer. It accepts push/pop requests from a producer and a consumer, generates the memory enables and addresses, and tracks occupancy with full/empty, almost-full/almost-empty and sticky error flags. It sits between the data source/sink logic and one dual-port memory instance, with matching `DATA_WIDTH`/`ADDR_WIDTH`/`MEM_SIZE`.

---
 rtl/fifo_controller_pkg.sv | 9 +
 rtl/wrap_counter.sv | 26 ++
 rtl/fifo_controller.sv | 99 +++++++++
 tb/tb_fifo_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_controller_pkg.sv
// Shared helpers for the FIFO controller slice.
// Pointer wrap is an explicit compare because the depth need not be a power of two.
package fifo_controller_pkg;

  function automatic bit isLastSlot(input int value, input int memSize);
    return (value == memSize - 1);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Address pointer that counts 0..MEM_SIZE-1 and wraps back to 0.
module wrap_counter
  import fifo_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_SIZE   = 7
) (
  input  logic                  Clock,
  input  logic                  iReset_n,
  input  logic                  iInc,
  output logic [ADDR_WIDTH-1:0] oValue
);

  logic atLast;

  assign atLast = isLastSlot(32'(oValue), MEM_SIZE);

  always_ff @(posedge Clock or negedge iReset_n) begin
    if (!iReset_n) begin
      oValue <= '0;
    end else if (iInc) begin
      oValue <= atLast ? '0 : oValue + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_controller.sv
// FIFO controller driving a registered-read dual-port memory: pointers, occupancy,
// threshold flags and sticky overflow/underflow errors.
module fifo_controller
  import fifo_controller_pkg::*;
#(
  parameter int DATA_WIDTH   = 6,
  parameter int ADDR_WIDTH   = 8,
  parameter int MEM_SIZE     = 7,
  parameter int ALMOST_FULL  = 5,
  parameter int ALMOST_EMPTY = 2
) (
  input  logic                  Clock,
  input  logic                  iReset_n,
  input  logic                  iPush,
  input  logic [DATA_WIDTH-1:0] iData,
  input  logic                  iPop,
  input  logic [DATA_WIDTH-1:0] iMemData,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0] oWriteData,
  output logic                  oReadEnable,
  output logic [ADDR_WIDTH-1:0] oReadAddress,
  output logic [DATA_WIDTH-1:0] oData,
  output logic                  oValid,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic                  oAlmostFull,
  output logic                  oAlmostEmpty,
  output logic [ADDR_WIDTH:0]   oCount,
  output logic                  oOverflow,
  output logic                  oUnderflow
);

  localparam logic [ADDR_WIDTH:0] FullCount        = (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH:0] AlmostFullCount  = (ADDR_WIDTH + 1)'(ALMOST_FULL);
  localparam logic [ADDR_WIDTH:0] AlmostEmptyCount = (ADDR_WIDTH + 1)'(ALMOST_EMPTY);

  logic [ADDR_WIDTH:0] count;
  logic                pushOk;
  logic                popOk;

  // Gating on the current flags resolves the full/empty push+pop corner cases.
  assign pushOk = iPush & ~oFull;
  assign popOk  = iPop & ~oEmpty;

  assign oFull        = (count == FullCount);
  assign oEmpty       = (count == '0);
  assign oAlmostFull  = (count >= AlmostFullCount);
  assign oAlmostEmpty = (count <= AlmostEmptyCount);
  assign oCount       = count;

  assign oWriteEnable = pushOk;
  assign oWriteData   = iData;
  assign oReadEnable  = popOk;
  assign oData        = iMemData;

  wrap_counter #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_SIZE  (MEM_SIZE)
  ) writePointer (
    .Clock   (Clock),
    .iReset_n(iReset_n),
    .iInc    (pushOk),
    .oValue  (oWriteAddress)
  );

  wrap_counter #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_SIZE  (MEM_SIZE)
  ) readPointer (
    .Clock   (Clock),
    .iReset_n(iReset_n),
    .iInc    (popOk),
    .oValue  (oReadAddress)
  );

  always_ff @(posedge Clock or negedge iReset_n) begin
    if (!iReset_n) begin
      count      <= '0;
      oValid     <= 1'b0;
      oOverflow  <= 1'b0;
      oUnderflow <= 1'b0;
    end else begin
      if (pushOk && !popOk) begin
        count <= count + 1'b1;
      end else if (popOk && !pushOk) begin
        count <= count - 1'b1;
      end
      oValid <= popOk;
      if (iPush && oFull) begin
        oOverflow <= 1'b1;
      end
      if (iPop && oEmpty) begin
        oUnderflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_controller.sv
// Directed bench for fifo_controller with a behavioural registered-read memory
// and a queue scoreboard holding the words expected to come back out.
module tb_fifo_controller;

  localparam int DW    = 6;
  localparam int AW    = 8;
  localparam int DEPTH = 7;
  localparam int AFULL = 5;
  localparam int AEMPT = 2;

  logic          clock;
  logic          resetN;
  logic          iPush;
  logic [DW-1:0] iData;
  logic          iPop;
  logic [DW-1:0] memOut;
  logic          oWriteEnable;
  logic [AW-1:0] oWriteAddress;
  logic [DW-1:0] oWriteData;
  logic          oReadEnable;
  logic [AW-1:0] oReadAddress;
  logic [DW-1:0] oData;
  logic          oValid;
  logic          oFull;
  logic          oEmpty;
  logic          oAlmostFull;
  logic          oAlmostEmpty;
  logic [AW:0]   oCount;
  logic          oOverflow;
  logic          oUnderflow;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  int            modelCount;
  int            modelWr;
  int            modelRd;
  bit            modelOver;
  bit            modelUnder;
  logic [DW-1:0] scoreQ [$];

  fifo_controller #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .MEM_SIZE    (DEPTH),
    .ALMOST_FULL (AFULL),
    .ALMOST_EMPTY(AEMPT)
  ) dut (
    .Clock        (clock),
    .iReset_n     (resetN),
    .iPush        (iPush),
    .iData        (iData),
    .iPop         (iPop),
    .iMemData     (memOut),
    .oWriteEnable (oWriteEnable),
    .oWriteAddress(oWriteAddress),
    .oWriteData   (oWriteData),
    .oReadEnable  (oReadEnable),
    .oReadAddress (oReadAddress),
    .oData        (oData),
    .oValid       (oValid),
    .oFull        (oFull),
    .oEmpty       (oEmpty),
    .oAlmostFull  (oAlmostFull),
    .oAlmostEmpty (oAlmostEmpty),
    .oCount       (oCount),
    .oOverflow    (oOverflow),
    .oUnderflow   (oUnderflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Dual-port memory stand-in: write at the edge, registered read one cycle later.
  always @(posedge clock) begin
    if (oWriteEnable) mem[oWriteAddress] <= oWriteData;
    if (oReadEnable) memOut <= mem[oReadAddress];
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int nextPtr(input int p);
    return (p == DEPTH - 1) ? 0 : p + 1;
  endfunction

  task automatic checkOutput(input bit validExp, input logic [DW-1:0] dataExp);
    check("valid", oValid, validExp);
    if (validExp) check("data", oData, dataExp);
    check("count", oCount, modelCount);
    check("full", oFull, modelCount == DEPTH);
    check("empty", oEmpty, modelCount == 0);
    check("almostFull", oAlmostFull, modelCount >= AFULL);
    check("almostEmpty", oAlmostEmpty, modelCount <= AEMPT);
    check("overflow", oOverflow, modelOver);
    check("underflow", oUnderflow, modelUnder);
  endtask

  task automatic applyStimulus(input bit push, input bit pop, input logic [DW-1:0] data);
    bit            acceptPush;
    bit            acceptPop;
    logic [DW-1:0] popped;
    iPush = push;
    iPop  = pop;
    iData = data;
    #1;
    acceptPush = push && (modelCount != DEPTH);
    acceptPop  = pop && (modelCount != 0);
    check("writeEnable", oWriteEnable, acceptPush);
    check("readEnable", oReadEnable, acceptPop);
    if (acceptPush) begin
      check("writeAddress", oWriteAddress, modelWr);
      check("writeData", oWriteData, data);
    end
    if (acceptPop) check("readAddress", oReadAddress, modelRd);
    @(posedge clock);
    #1;
    iPush  = 1'b0;
    iPop   = 1'b0;
    popped = '0;
    if (acceptPop) begin
      popped = scoreQ.pop_front();
      modelRd = nextPtr(modelRd);
      modelCount--;
    end
    if (acceptPush) begin
      scoreQ.push_back(data);
      modelWr = nextPtr(modelWr);
      modelCount++;
    end
    if (push && !acceptPush) modelOver = 1'b1;
    if (pop && !acceptPop) modelUnder = 1'b1;
    checkOutput(acceptPop, popped);
  endtask

  task automatic doReset();
    iPush  = 1'b0;
    iPop   = 1'b0;
    resetN = 1'b0;
    #1;
    modelCount = 0;
    modelWr    = 0;
    modelRd    = 0;
    modelOver  = 1'b0;
    modelUnder = 1'b0;
    scoreQ.delete();
    check("resetWriteEnable", oWriteEnable, 1'b0);
    check("resetReadEnable", oReadEnable, 1'b0);
    checkOutput(1'b0, '0);
    @(negedge clock);
    resetN = 1'b1;
    #1;
  endtask

  initial begin
    logic [DW-1:0] word;
    resetN = 1'b0;
    iPush  = 1'b0;
    iPop   = 1'b0;
    iData  = '0;
    #2;
    doReset();

    // Fill to full, then one rejected push
    for (int i = 1; i <= 8; i++) begin
      word = DW'(i);
      applyStimulus(1'b1, 1'b0, word);
    end
    // Drain, then one rejected pop
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, '0);

    // Wrap: move pointers to 5, then push across the boundary
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 6'h10);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, '0);
    for (int i = 0; i < 5; i++) begin
      word = 6'h2A + DW'(i);
      applyStimulus(1'b1, 1'b0, word);
    end
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, '0);

    // Simultaneous push+pop at count 3, at empty and at full
    doReset();
    for (int i = 0; i < 3; i++) begin
      word = 6'h30 + DW'(i);
      applyStimulus(1'b1, 1'b0, word);
    end
    applyStimulus(1'b1, 1'b1, 6'h33);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b1, 1'b1, 6'h15);
    for (int i = 0; i < 6; i++) begin
      word = 6'h20 + DW'(i);
      applyStimulus(1'b1, 1'b0, word);
    end
    applyStimulus(1'b1, 1'b1, 6'h3F);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, '0);

    // Reset while a popped word is being presented
    doReset();
    applyStimulus(1'b1, 1'b0, 6'h05);
    applyStimulus(1'b1, 1'b0, 6'h06);
    applyStimulus(1'b0, 1'b1, '0);
    #2;
    doReset();
    checkOutput(1'b0, '0);
    applyStimulus(1'b1, 1'b0, 6'h0B);
    applyStimulus(1'b0, 1'b1, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
